// File: rtl/flow_rate_limiter_pkg.sv
// flow_rate_limiter_pkg: shared gate states, stats width
// and the saturating token-update helper.
package flow_rate_limiter_pkg;

   typedef enum logic [1:0] {
      FULL     = 2'd0,
      LIMITING = 2'd1,
      STARVED  = 2'd2
   } gate_state_t;

   localparam int STATS_WIDTH = 32;
   localparam int TOK_CALC_W  = 34;

   // Wide enough that refill-then-consume can neither wrap nor underflow.
   function automatic logic [31:0] tok_update(
      input logic [31:0] tokens,
      input logic        refill,
      input logic        consume,
      input logic [31:0] amount,
      input logic [31:0] ceiling
   );
      logic [TOK_CALC_W-1:0] sum;
      sum = {2'b00, tokens};
      if (refill)
         sum = sum + {2'b00, amount};
      if (consume)
         sum = sum - TOK_CALC_W'(1);
      if (sum > {2'b00, ceiling})
         sum = {2'b00, ceiling};
      return sum[31:0];
   endfunction

endpackage

// File: rtl/rl_skid_buf.sv
// rl_skid_buf: 2-entry in-order valid/ready skid buffer;
// not_full comes from registers only.
module rl_skid_buf #(
   parameter int DATA_WIDTH = 512
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  push,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  not_full
);

   logic [1:0]            cnt_q;
   logic [DATA_WIDTH-1:0] d0_q;
   logic [DATA_WIDTH-1:0] d1_q;
   logic                  pop;

   assign out_valid = (cnt_q != 2'd0);
   assign not_full  = (cnt_q != 2'd2);
   assign out_data  = d0_q;
   assign pop       = out_valid & out_ready;

   // d0_q is always the head; push is never seen while full.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= 2'd0;
         d0_q  <= '0;
         d1_q  <= '0;
      end else begin
         if (pop) begin
            if (cnt_q == 2'd2)
               d0_q <= d1_q;
            else if (push)
               d0_q <= in_data;
         end else if (push) begin
            if (cnt_q == 2'd0)
               d0_q <= in_data;
            else
               d1_q <= in_data;
         end
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/flow_rate_limiter.sv
// flow_rate_limiter: token-bucket admission ahead of a skid buffer.
// Define FLOW_RATE_LIMITER_STATS_EN to build the pass/throttle counters.
module flow_rate_limiter
   import flow_rate_limiter_pkg::*;
#(
   parameter int DATA_WIDTH    = 512,
   parameter int TOKEN_WIDTH   = 16,
   parameter int BUCKET_MAX    = 64,
   parameter int REFILL_PERIOD = 4,
   parameter int REFILL_AMOUNT = 1
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   cfg_enable,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [1:0]             gate_state,
   output logic [STATS_WIDTH-1:0] stats_pass,
   output logic [STATS_WIDTH-1:0] stats_throttle
);

   localparam int RC_W =
      (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
   localparam logic [TOKEN_WIDTH-1:0] TOK_MAX =
      TOKEN_WIDTH'(BUCKET_MAX);
   localparam logic [RC_W-1:0] RC_LAST =
      RC_W'(REFILL_PERIOD - 1);

   logic [TOKEN_WIDTH-1:0] tokens_q;
   logic [TOKEN_WIDTH-1:0] tokens_d;
   logic [RC_W-1:0]        rc_q;
   gate_state_t            gate_q;
   gate_state_t            gate_d;
   logic                   skid_not_full;
   logic                   has_tokens;
   logic                   accept;
   logic                   consume;
   logic                   refill;

   assign has_tokens = (tokens_q != '0);
   assign in_ready   = skid_not_full & (~cfg_enable | has_tokens);
   assign accept     = in_valid & in_ready;
   assign consume    = accept & cfg_enable;
   assign refill     = (rc_q == RC_LAST);
   assign tokens_d   = TOKEN_WIDTH'(tok_update(
      32'(tokens_q), refill, consume,
      32'(REFILL_AMOUNT), 32'(BUCKET_MAX)));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         tokens_q <= TOK_MAX;
         rc_q     <= '0;
      end else begin
         tokens_q <= tokens_d;
         rc_q     <= refill ? '0 : rc_q + RC_W'(1);
      end
   end

   always_comb begin
      gate_d = LIMITING;
      unique case (1'b1)
         (tokens_d == TOK_MAX): gate_d = FULL;
         (tokens_d == '0):      gate_d = STARVED;
         default:               gate_d = LIMITING;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         gate_q <= FULL;
      else
         gate_q <= gate_d;
   end

   assign gate_state = gate_q;

   rl_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .in_data   (in_data),
      .push      (accept),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .not_full  (skid_not_full)
   );

`ifdef FLOW_RATE_LIMITER_STATS_EN
   logic [STATS_WIDTH-1:0] pass_q;
   logic [STATS_WIDTH-1:0] thr_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pass_q <= '0;
         thr_q  <= '0;
      end else begin
         if (out_valid & out_ready)
            pass_q <= pass_q + STATS_WIDTH'(1);
         if (in_valid & cfg_enable & skid_not_full & ~has_tokens)
            thr_q <= thr_q + STATS_WIDTH'(1);
      end
   end

   assign stats_pass     = pass_q;
   assign stats_throttle = thr_q;
`else
   assign stats_pass     = '0;
   assign stats_throttle = '0;
`endif

endmodule
